// File: rtl/instr_buf_pkg.sv
// Shared types and default sizes for the ping-pong instruction reorder buffer.
package instr_buf_pkg;
    localparam int INSTR_W_DEF = 32;
    localparam int DEPTH_DEF   = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;
endpackage

// File: rtl/instr_buf_bank.sv
// One bank: sequentially written storage, per-entry valid bits, sealed count and state.
module instr_buf_bank
    import instr_buf_pkg::*;
#(
    parameter  int INSTR_W = INSTR_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               seal,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               clear,
    output bank_state_t        state,
    output logic [IDX_W:0]     count,
    output logic [INSTR_W-1:0] rd_data,
    output logic               rd_ok
);
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // A write and a clear never hit the same bank in one cycle: clear needs FULL, write needs !FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            count <= '0;
            valid <= '0;
        end else begin
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
                if (seal) begin
                    state <= FULL;
                    count <= {1'b0, wr_idx} + 1'b1;
                end else if (state == EMPTY) begin
                    state <= FILLING;
                end
            end
            if (rd_en) valid[rd_idx] <= 1'b0;
            if (clear) state <= EMPTY;
        end
    end

    assign rd_data = mem[rd_idx];
    assign rd_ok   = (state == FULL) && ({1'b0, rd_idx} < count) && valid[rd_idx];
endmodule

// File: rtl/instr_reorder_buffer.sv
// Ping-pong instruction buffer: fill one bank in order, drain the other by mapped index.
module instr_reorder_buffer
    import instr_buf_pkg::*;
#(
    parameter  int INSTR_W = INSTR_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_last,
    output logic               start,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_err,
    output logic [IDX_W:0]     drain_left
);
    bank_state_t                 state [2];
    logic [1:0][IDX_W:0]         count;
    logic [1:0][INSTR_W-1:0]     rd_data;
    logic [1:0]                  rd_ok;

    logic             fb, db;
    logic [IDX_W-1:0] wr_ptr;
    logic             wr_acc, seal, rd_acc, rd_rej, rel;
    logic [IDX_W:0]   seal_cnt;

    assign in_ready = (state[fb] != FULL);
    assign start    = (state[db] == FULL);
    assign wr_acc   = in_valid && in_ready;
    assign seal     = wr_acc && (in_last || (wr_ptr == IDX_W'(DEPTH - 1)));
    assign seal_cnt = {1'b0, wr_ptr} + 1'b1;
    assign rd_acc   = rd_req && start && rd_ok[db];
    assign rd_rej   = rd_req && !rd_acc;
    assign rel      = rd_acc && (drain_left == (IDX_W+1)'(1));

    for (genvar g = 0; g < 2; g++) begin : g_bank
        instr_buf_bank #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_acc && (fb == 1'(g))),
            .wr_idx  (wr_ptr),
            .wr_data (in_instr),
            .seal    (seal),
            .rd_en   (rd_acc && (db == 1'(g))),
            .rd_idx  (rd_index),
            .clear   (rel && (db == 1'(g))),
            .state   (state[g]),
            .count   (count[g]),
            .rd_data (rd_data[g]),
            .rd_ok   (rd_ok[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb         <= 1'b0;
            db         <= 1'b0;
            wr_ptr     <= '0;
            drain_left <= '0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            out_instr  <= '0;
        end else begin
            out_valid <= rd_acc;
            out_err   <= rd_rej;
            if (rd_acc) out_instr <= rd_data[db];
            if (wr_acc) begin
                if (seal) begin
                    wr_ptr <= '0;
                    fb     <= ~fb;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            // On release the other bank becomes the drain bank; it may be sealing this very cycle.
            if (rel) begin
                db         <= ~db;
                drain_left <= (state[~db] == FULL) ? count[~db] : (seal ? seal_cnt : '0);
            end else if (rd_acc) begin
                drain_left <= drain_left - 1'b1;
            end else if (seal && (fb == db)) begin
                drain_left <= seal_cnt;
            end
        end
    end
endmodule

// File: tb/tb_instr_reorder_buffer.sv
// Randomized + directed bench for instr_reorder_buffer against a queue-level bank model.
module tb_instr_reorder_buffer;
    localparam int W = 32;
    localparam int D = 16;
    localparam int IW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_last = 1'b0, rd_req = 1'b0;
    logic [W-1:0]  in_instr = '0;
    logic [IW-1:0] rd_index = '0;
    logic          in_ready, start, out_valid, out_err;
    logic [W-1:0]  out_instr;
    logic [IW:0]   drain_left;

    int n_cmp = 0, n_bad = 0;

    instr_reorder_buffer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_last(in_last), .start(start), .rd_req(rd_req),
        .rd_index(rd_index), .out_valid(out_valid), .out_instr(out_instr),
        .out_err(out_err), .drain_left(drain_left)
    );

    always #5 clk = ~clk;

    // Model: bank mode 0=empty 1=filling 2=full; avail marks entries still unread.
    int           m_mode [2];
    logic [W-1:0] m_data [2][D];
    bit           m_avail [2][D];
    int           m_cnt [2];
    int           m_fb, m_db, m_wp;
    bit           m_wacc;
    bit           e_ov, e_oe;
    logic [W-1:0] e_oi;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unread(input int b);
        int n = 0;
        for (int i = 0; i < D; i++) if (m_avail[b][i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_mode[b] = 0;
            m_cnt[b]  = 0;
            for (int i = 0; i < D; i++) m_avail[b][i] = 0;
        end
        m_fb = 0; m_db = 0; m_wp = 0; m_wacc = 0;
        e_ov = 0; e_oe = 0; e_oi = '0;
    endtask

    task automatic model_update();
        int  fb0, db0, ix;
        bit  racc, wacc;
        if (rst) begin
            model_reset();
            return;
        end
        fb0  = m_fb;
        db0  = m_db;
        ix   = int'(rd_index);
        racc = rd_req && m_mode[db0] == 2 && ix < m_cnt[db0] && m_avail[db0][ix];
        wacc = in_valid && m_mode[fb0] != 2;
        e_ov = racc;
        e_oe = rd_req && !racc;
        if (racc) begin
            e_oi = m_data[db0][ix];
            m_avail[db0][ix] = 0;
            if (unread(db0) == 0) begin
                m_mode[db0] = 0;
                m_db = 1 - db0;
            end
        end
        if (wacc) begin
            m_data[fb0][m_wp]  = in_instr;
            m_avail[fb0][m_wp] = 1;
            m_mode[fb0] = 1;
            if (in_last || m_wp == D - 1) begin
                m_mode[fb0] = 2;
                m_cnt[fb0]  = m_wp + 1;
                m_wp = 0;
                m_fb = 1 - fb0;
            end else begin
                m_wp++;
            end
        end
        m_wacc = wacc;
    endtask

    // Check outputs mid-cycle, then let the edge happen with the current inputs.
    task automatic tick();
        @(negedge clk);
        chk("in_ready", in_ready, m_mode[m_fb] != 2);
        chk("start", start, m_mode[m_db] == 2);
        chk("drain_left", drain_left, (m_mode[m_db] == 2) ? unread(m_db) : 0);
        chk("out_valid", out_valid, e_ov);
        chk("out_err", out_err, e_oe);
        chk("out_instr", out_instr, e_oi);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit l, input bit rq, input int ix);
        in_valid = v; in_instr = d; in_last = l; rd_req = rq; rd_index = IW'(ix);
        tick();
    endtask

    task automatic wr(input logic [W-1:0] d, input bit l);
        int n = 0;
        in_valid = 1; in_instr = d; in_last = l; rd_req = 0;
        do begin
            tick();
            n++;
        end while (!m_wacc && n < 100);
        if (!m_wacc) chk("wr_timeout", 0, 1);
        in_valid = 0; in_last = 0;
    endtask

    task automatic drain_perm(input int n);
        int p [D];
        for (int i = 0; i < n; i++) p[i] = i;
        for (int i = n - 1; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            int t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 1, p[i]);
    endtask

    initial begin
        int first [3];
        bit used [D];
        first = '{15, 3, 0};
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        tick();

        // 16 words fill bank 0, then a permuted full drain led by 15,3,0
        for (int i = 0; i < D; i++) wr(W'(32'h100 + i), 0);
        for (int i = 0; i < D; i++) used[i] = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, 0, 1, first[i]);
            used[first[i]] = 1;
        end
        for (int i = 0; i < D; i++) if (!used[i]) cyc(0, '0, 0, 1, i);
        cyc(0, '0, 0, 0, 0);

        // Short bank via in_last; out-of-range and duplicate reads
        for (int i = 0; i < 5; i++) wr(W'(32'h500 + i), i == 4);
        cyc(0, '0, 0, 1, 7);
        cyc(0, '0, 0, 1, 2);
        cyc(0, '0, 0, 1, 2);
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 1, 1);
        cyc(0, '0, 0, 1, 3);
        cyc(0, '0, 0, 1, 4);
        cyc(0, '0, 0, 0, 0);

        // Both banks full; a 33rd word is held until bank 0 is released
        for (int i = 0; i < 2 * D; i++) wr(W'(32'h300 + i), 0);
        for (int i = 0; i < 3; i++) cyc(1, 32'h333, 0, 0, 0);
        begin
            bit pend = 1;
            for (int i = 0; i < D; i++) begin
                cyc(pend, 32'h333, 0, 1, i);
                if (m_wacc) pend = 0;
            end
            for (int i = 0; i < 4 && pend; i++) begin
                cyc(1, 32'h333, 0, 0, 0);
                if (m_wacc) pend = 0;
            end
            if (pend) chk("held_word_timeout", 0, 1);
        end
        drain_perm(D);
        wr(32'h334, 1);
        drain_perm(2);
        cyc(0, '0, 0, 0, 0);

        // Concurrent: drain one bank while the other is written every cycle
        for (int i = 0; i < D; i++) wr(W'(32'h100 + i), 0);
        for (int i = 0; i < D; i++) cyc(1, W'(32'h200 + i), 0, 1, D - 1 - i);
        drain_perm(D);
        cyc(0, '0, 0, 0, 0);

        // Reset mid-fill discards everything
        for (int i = 0; i < 8; i++) wr(W'(32'h700 + i), 0);
        rst = 1;
        cyc(0, '0, 0, 1, 0);
        rst = 0;
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0);

        // Random traffic; producer holds a stalled word
        for (int c = 0; c < 3000; c++) begin
            bit hold = in_valid && !m_wacc && !rst;
            rst = ($urandom_range(599, 0) == 0);
            if (!hold) begin
                in_valid = ($urandom_range(2, 0) != 0);
                in_instr = $urandom;
                in_last  = ($urandom_range(7, 0) == 0);
            end
            rd_req   = $urandom_range(1, 0);
            rd_index = IW'($urandom_range(D - 1, 0));
            tick();
        end
        rst = 0;
        cyc(0, '0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
